// File: rtl/touch_frame_decoder.sv
// Touch-panel frame decoder: turns a panel interrupt into a 10-byte register burst
// request, then decodes gesture, touch count and two clamped coordinates.
module touch_frame_decoder #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int X_MAX       = 799,
    parameter int Y_MAX       = 479
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iINT_N,
    output logic       oRD_REQ,
    input  logic       iRD_ACK,
    input  logic       iBYTE_VALID,
    input  logic [7:0] iBYTE,
    input  logic       iRD_DONE,
    input  logic       iRD_ERR,
    output logic       oREADY,
    output logic [7:0] oREG_GESTURE,
    output logic [9:0] ox1,
    output logic [9:0] ox2,
    output logic [8:0] oy1,
    output logic [8:0] oy2,
    output logic [1:0] otouch_count,
    output logic       oERR
);

    localparam int          FRAME_LEN   = 10;
    localparam logic [3:0]  LAST_IDX    = 4'(FRAME_LEN);
    localparam logic [11:0] X_CLAMP     = 12'(X_MAX);
    localparam logic [11:0] Y_CLAMP     = 12'(Y_MAX);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        COMMIT,
        ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        int_meta;
    logic        int_sync;
    logic        int_prev;
    logic        trigger;
    logic        pending;
    logic [3:0]  byte_idx;
    logic [3:0]  idx_next;
    logic        byte_accept;
    logic [15:0] timeout_cnt;
    logic        timeout_hit;
    logic        load_frame;
    logic [7:0]  shadow      [FRAME_LEN];
    logic [7:0]  shadow_next [FRAME_LEN];

    logic [11:0] raw_x1;
    logic [11:0] raw_y1;
    logic [11:0] raw_x2;
    logic [11:0] raw_y2;
    logic [11:0] clamp_x1;
    logic [11:0] clamp_y1;
    logic [11:0] clamp_x2;
    logic [11:0] clamp_y2;
    logic [1:0]  dec_count;

    function automatic logic [11:0] clamp12(input logic [11:0] value, input logic [11:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    // Interrupt arrives asynchronously; only a falling edge after synchronisation counts.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
            int_prev <= 1'b0;
        end else begin
            int_meta <= iINT_N;
            int_sync <= int_meta;
            int_prev <= int_sync;
        end
    end

    assign trigger     = int_prev & ~int_sync;
    assign byte_accept = (state == RECV) && iBYTE_VALID && (byte_idx < LAST_IDX);
    assign idx_next    = byte_idx + {3'd0, byte_accept};
    assign timeout_hit = ({16'd0, timeout_cnt} >= TIMEOUT_LIM);
    assign load_frame  = (state == RECV) && (next_state == COMMIT);

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A byte landing in the same cycle as DONE is counted before the length check.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (iRD_ACK) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                if (iRD_ERR) begin
                    next_state = ERR;
                end else if (iRD_DONE) begin
                    next_state = (idx_next == LAST_IDX) ? COMMIT : ERR;
                end else if (timeout_hit) begin
                    next_state = ERR;
                end
            end
            COMMIT, ERR: begin
                next_state = (pending || trigger) ? REQ : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // At most one interrupt is remembered while a frame is in flight.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            pending <= 1'b0;
        end else if (state == COMMIT || state == ERR) begin
            pending <= 1'b0;
        end else if (trigger && state != IDLE) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            byte_idx    <= 4'd0;
            timeout_cnt <= 16'd0;
        end else if (state == REQ && iRD_ACK) begin
            byte_idx    <= 4'd0;
            timeout_cnt <= 16'd0;
        end else if (state == RECV) begin
            byte_idx <= idx_next;
            if (timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            shadow_next[i] = shadow[i];
        end
        if (byte_accept) begin
            shadow_next[byte_idx] = iBYTE;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                shadow[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                shadow[i] <= shadow_next[i];
            end
        end
    end

    // Decode from the post-write shadow so outputs are valid in the same cycle as oREADY.
    always_comb begin
        raw_x1   = {shadow_next[2][3:0], shadow_next[3]};
        raw_y1   = {shadow_next[4][3:0], shadow_next[5]};
        raw_x2   = {shadow_next[6][3:0], shadow_next[7]};
        raw_y2   = {shadow_next[8][3:0], shadow_next[9]};
        clamp_x1 = clamp12(raw_x1, X_CLAMP);
        clamp_y1 = clamp12(raw_y1, Y_CLAMP);
        clamp_x2 = clamp12(raw_x2, X_CLAMP);
        clamp_y2 = clamp12(raw_y2, Y_CLAMP);
        case (shadow_next[1][3:0])
            4'd0:    dec_count = 2'd0;
            4'd1:    dec_count = 2'd1;
            default: dec_count = 2'd2;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oREG_GESTURE <= 8'd0;
            otouch_count <= 2'd0;
            ox1          <= 10'd0;
            oy1          <= 9'd0;
            ox2          <= 10'd0;
            oy2          <= 9'd0;
        end else if (load_frame) begin
            oREG_GESTURE <= shadow_next[0];
            otouch_count <= dec_count;
            ox1          <= (dec_count == 2'd0) ? 10'd0 : clamp_x1[9:0];
            oy1          <= (dec_count == 2'd0) ? 9'd0  : clamp_y1[8:0];
            ox2          <= (dec_count != 2'd2) ? 10'd0 : clamp_x2[9:0];
            oy2          <= (dec_count != 2'd2) ? 9'd0  : clamp_y2[8:0];
        end
    end

    assign oRD_REQ = (state == REQ);
    assign oREADY  = (state == COMMIT);
    assign oERR    = (state == ERR);

endmodule

// File: tb/tb_touch_frame_decoder.sv
// Directed bench for touch_frame_decoder: table of decoded frames plus hand-built
// sequences for short bursts, errors, timeout, pending interrupts and mid-frame reset.
module tb_touch_frame_decoder;

    localparam int TIMEOUT_CYC = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_n;
    logic       rd_req;
    logic       rd_ack;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rd_done;
    logic       rd_err;
    logic       ready;
    logic [7:0] gesture;
    logic [9:0] x1;
    logic [9:0] x2;
    logic [8:0] y1;
    logic [8:0] y2;
    logic [1:0] touch_count;
    logic       err;

    typedef struct {
        logic [79:0] bytes;
        logic [7:0]  g;
        logic [1:0]  c;
        logic [9:0]  x1;
        logic [8:0]  y1;
        logic [9:0]  x2;
        logic [8:0]  y2;
    } vec_t;

    localparam int NUM_VEC = 6;
    vec_t vecs [NUM_VEC];

    int tests_run    = 0;
    int tests_failed = 0;
    int ready_seen   = 0;
    int err_seen     = 0;

    touch_frame_decoder #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .X_MAX      (799),
        .Y_MAX      (479)
    ) dut (
        .iCLK        (clk),
        .iRSTN       (rst_n),
        .iINT_N      (int_n),
        .oRD_REQ     (rd_req),
        .iRD_ACK     (rd_ack),
        .iBYTE_VALID (byte_valid),
        .iBYTE       (byte_data),
        .iRD_DONE    (rd_done),
        .iRD_ERR     (rd_err),
        .oREADY      (ready),
        .oREG_GESTURE(gesture),
        .ox1         (x1),
        .ox2         (x2),
        .oy1         (y1),
        .oy2         (y2),
        .otouch_count(touch_count),
        .oERR        (err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        if (ready) ready_seen++;
        if (err) err_seen++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        check_output({tag, "_gesture"}, 32'(gesture), 32'(v.g));
        check_output({tag, "_count"}, 32'(touch_count), 32'(v.c));
        check_output({tag, "_x1"}, 32'(x1), 32'(v.x1));
        check_output({tag, "_y1"}, 32'(y1), 32'(v.y1));
        check_output({tag, "_x2"}, 32'(x2), 32'(v.x2));
        check_output({tag, "_y2"}, 32'(y2), 32'(v.y2));
    endtask

    task automatic start_frame();
        int waited = 0;
        int_n = 1'b0;
        while (!rd_req && waited < 20) begin
            tick();
            waited++;
        end
        check_output("rd_req_raise", 32'(rd_req), 1);
        int_n = 1'b1;
        repeat (3) tick();
        check_output("rd_req_hold", 32'(rd_req), 1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check_output("rd_req_drop", 32'(rd_req), 0);
    endtask

    task automatic send_bytes(input logic [79:0] fb, input int n, input bit done_on_last);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = fb[79 - 8 * i -: 8];
            if (done_on_last && i == n - 1) rd_done = 1'b1;
            tick();
            byte_valid = 1'b0;
            byte_data  = 8'd0;
            rd_done    = 1'b0;
        end
    endtask

    task automatic pulse_end(input bit done, input bit abort);
        rd_done = done;
        rd_err  = abort;
        tick();
        rd_done = 1'b0;
        rd_err  = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input bit done_on_last);
        start_frame();
        send_bytes(v.bytes, 10, done_on_last);
        if (!done_on_last) pulse_end(1'b1, 1'b0);
    endtask

    initial begin
        int r0;
        int e0;
        int cyc;
        int hi;

        vecs[0] = '{80'h00_02_01_2C_00_C8_02_58_01_90, 8'h00, 2'd2, 10'd300, 9'd200, 10'd600, 9'd400};
        vecs[1] = '{80'h48_01_0F_FF_0F_FF_01_00_01_00, 8'h48, 2'd1, 10'd799, 9'd479, 10'd0,   9'd0};
        vecs[2] = '{80'h11_00_01_00_01_00_01_00_01_00, 8'h11, 2'd0, 10'd0,   9'd0,   10'd0,   9'd0};
        vecs[3] = '{80'h05_02_03_1F_01_DF_03_20_01_E0, 8'h05, 2'd2, 10'd799, 9'd479, 10'd799, 9'd479};
        vecs[4] = '{80'hA7_FF_F0_05_F0_07_F1_00_E0_00, 8'hA7, 2'd2, 10'd5,   9'd7,   10'd256, 9'd0};
        vecs[5] = '{80'h00_03_00_00_00_00_00_00_00_01, 8'h00, 2'd2, 10'd0,   9'd0,   10'd0,   9'd1};

        rst_n      = 1'b0;
        int_n      = 1'b1;
        rd_ack     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        rd_done    = 1'b0;
        rd_err     = 1'b0;
        repeat (3) tick();
        check_output("reset_pulses", {29'd0, rd_req, ready, err}, 0);
        check_output("reset_coords", {gesture, touch_count, x1, y1}, 0);
        check_output("reset_coords2", {13'd0, x2, y2}, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Table of frames; odd entries deliver the last byte together with DONE.
        for (int i = 0; i < NUM_VEC; i++) begin
            r0 = ready_seen;
            apply_stimulus(vecs[i], (i % 2) == 1);
            check_output($sformatf("vec%0d_ready", i), 32'(ready), 1);
            check_output($sformatf("vec%0d_err", i), 32'(err), 0);
            check_frame($sformatf("vec%0d", i), vecs[i]);
            tick();
            check_output($sformatf("vec%0d_ready_pulse", i), 32'(ready), 0);
            repeat (3) tick();
            check_output($sformatf("vec%0d_ready_count", i), 32'(ready_seen - r0), 1);
        end

        // Short burst of 7 bytes.
        r0 = ready_seen;
        e0 = err_seen;
        start_frame();
        send_bytes(vecs[0].bytes, 7, 1'b0);
        pulse_end(1'b1, 1'b0);
        check_output("short_err", 32'(err), 1);
        check_output("short_ready", 32'(ready), 0);
        check_frame("short_hold", vecs[5]);
        tick();
        check_output("short_err_pulse", 32'(err), 0);
        repeat (3) tick();
        check_output("short_ready_count", 32'(ready_seen - r0), 0);
        check_output("short_err_count", 32'(err_seen - e0), 1);

        // Full frame but ERR and DONE together.
        r0 = ready_seen;
        start_frame();
        send_bytes(vecs[0].bytes, 10, 1'b0);
        pulse_end(1'b1, 1'b1);
        check_output("errdone_err", 32'(err), 1);
        check_output("errdone_ready", 32'(ready), 0);
        check_frame("errdone_hold", vecs[5]);
        repeat (3) tick();
        check_output("errdone_ready_count", 32'(ready_seen - r0), 0);

        // Timeout with no bytes after ACK.
        start_frame();
        cyc = 0;
        while (!err && cyc < 200) begin
            tick();
            cyc++;
        end
        check_output("timeout_err", 32'(err), 1);
        check_output("timeout_latency", 32'(cyc >= TIMEOUT_CYC && cyc <= TIMEOUT_CYC + 3), 1);
        check_frame("timeout_hold", vecs[5]);
        hi = 0;
        repeat (20) begin
            tick();
            if (rd_req) hi++;
        end
        check_output("timeout_no_req", 32'(hi), 0);

        // Two further interrupt falls during RECV collapse into one pending frame.
        r0 = ready_seen;
        start_frame();
        send_bytes(vecs[0].bytes, 3, 1'b0);
        int_n = 1'b0;
        repeat (4) tick();
        int_n = 1'b1;
        repeat (4) tick();
        int_n = 1'b0;
        repeat (4) tick();
        int_n = 1'b1;
        repeat (4) tick();
        send_bytes(vecs[0].bytes << 24, 7, 1'b0);
        pulse_end(1'b1, 1'b0);
        check_output("pend_ready1", 32'(ready), 1);
        check_frame("pend_frame1", vecs[0]);
        tick();
        check_output("pend_req_next", 32'(rd_req), 1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        send_bytes(vecs[1].bytes, 10, 1'b1);
        check_output("pend_ready2", 32'(ready), 1);
        check_frame("pend_frame2", vecs[1]);
        hi = 0;
        repeat (20) begin
            tick();
            if (rd_req) hi++;
        end
        check_output("pend_single", 32'(hi), 0);
        check_output("pend_ready_count", 32'(ready_seen - r0), 2);

        // Reset asserted while receiving.
        r0 = ready_seen;
        e0 = err_seen;
        start_frame();
        send_bytes(vecs[0].bytes, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_pulses", {29'd0, rd_req, ready, err}, 0);
        check_output("midrst_coords", {gesture, touch_count, x1, y1}, 0);
        check_output("midrst_coords2", {13'd0, x2, y2}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_output("midrst_no_ready", 32'(ready_seen - r0), 0);
        check_output("midrst_no_err", 32'(err_seen - e0), 0);
        check_output("midrst_idle", 32'(rd_req), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
